// File: rtl/mem_bus_port_if.sv
// Bus/memory signal bundle for the MAR/MDR memory port.
// The slave modport is the port itself; master is the control unit plus memory side.
interface mem_bus_port_if;
   logic [15:0] bus_in;
   logic        LD_MAR;
   logic        LD_MDR;
   logic        rd_start;
   logic        wr_start;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] MAR_out;
   logic [15:0] MDR_out;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        err;

   modport slave (
      input  bus_in, LD_MAR, LD_MDR, rd_start, wr_start, mem_rdata, mem_ready,
      output MAR_out, MDR_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
   );

   modport master (
      output bus_in, LD_MAR, LD_MDR, rd_start, wr_start, mem_rdata, mem_ready,
      input  MAR_out, MDR_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
   );
endinterface

// File: rtl/mem_bus_port.sv
// Memory port at the consumer end of the internal bus: holds MAR/MDR and runs
// single-word read/write transactions with a ready handshake and bounded wait.
module mem_bus_port #(
   parameter int WAIT_LIMIT = 8
) (
   input  logic            Clk,
   input  logic            Reset,
   mem_bus_port_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

   state_t      state_q, state_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Loads are applied in the same cycle as a start, so the new transaction
   // sees the freshly loaded MAR/MDR; a simultaneous read beats a write.
   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.LD_MAR) mar_d = bus.bus_in;
            if (bus.LD_MDR) mdr_d = bus.bus_in;
            if (bus.rd_start) begin
               state_d = READ;
               cnt_d   = '0;
            end else if (bus.wr_start) begin
               state_d = WRITE;
               cnt_d   = '0;
            end
         end
         READ, WRITE: begin
            if (bus.mem_ready) begin
               if (state_q == READ) mdr_d = bus.mem_rdata;
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (cnt_q == LAST_WAIT) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.MAR_out   = mar_q;
      bus.MDR_out   = mdr_q;
      bus.mem_addr  = mar_q;
      bus.mem_wdata = mdr_q;
      bus.mem_req   = (state_q != IDLE);
      bus.mem_we    = (state_q == WRITE);
      bus.busy      = (state_q != IDLE);
      bus.done      = done_q;
      bus.err       = err_q;
   end

endmodule
